// File: rtl/life_grid.sv
// Purpose: X-by-Y Game of Life grid, advanced a programmable number of generations per step command.
// Latency: Y+1 cycles per generation (one PREP cycle, then one row per cycle); rd_data registered, 1 cycle.
// Backpressure: none; load_valid and step are ignored while busy, host waits for done.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   load_valid, load_row, load_data  row write (IDLE only; rows >= Y dropped)
//   step, gens                       start command and generation count (gens = 0 -> immediate done)
//   busy, done                       run in progress / one-cycle completion pulse
//   gen_count                        generations completed since reset (wraps)
//   rd_row, rd_data                  registered row read port (rd_row >= Y reads 0)
module life_grid #(
    parameter int         X       = 8,
    parameter int         Y       = 8,
    parameter int         LOG2Y   = 3,
    parameter logic [8:0] BIRTH   = 9'b000001000,
    parameter logic [8:0] SURVIVE = 9'b000001100,
    parameter bit         WRAP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [LOG2Y-1:0] load_row,
    input  logic [X-1:0]     load_data,
    input  logic             step,
    input  logic [7:0]       gens,
    output logic             busy,
    output logic             done,
    output logic [15:0]      gen_count,
    input  logic [LOG2Y-1:0] rd_row,
    output logic [X-1:0]     rd_data
);

    typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;

    localparam logic [LOG2Y:0] Y_EXT = (LOG2Y+1)'(Y);

    state_t           state_q, state_d;
    logic             done_d;
    logic [X-1:0]     grid [Y];
    logic [X-1:0]     prev_row, row0_save;
    logic [X-1:0]     cur_row, below_row, new_row;
    logic [LOG2Y-1:0] r;
    logic [7:0]       gens_left;
    logic             last_row;
    logic             load_ok, rd_ok;

    assign last_row = (r == LOG2Y'(Y - 1));
    assign load_ok  = ({1'b0, load_row} < Y_EXT);
    assign rd_ok    = ({1'b0, rd_row} < Y_EXT);

    // Row r is still unmodified when it is processed; the row above was already
    // overwritten, so its old value comes from prev_row. Row 0 is gone by the
    // time the last row needs it as its lower neighbour, hence row0_save.
    assign cur_row   = grid[r];
    assign below_row = last_row ? (WRAP ? row0_save : '0) : grid[r + LOG2Y'(1)];

    for (genvar c = 0; c < X; c++) begin : g_cell
        localparam int CL    = (c == 0)     ? X - 1 : c - 1;
        localparam int CR    = (c == X - 1) ? 0     : c + 1;
        localparam bit HAS_L = WRAP || (c != 0);
        localparam bit HAS_R = WRAP || (c != X - 1);
        logic [3:0] n;
        assign n = 4'(prev_row[c]) + 4'(below_row[c])
                 + (HAS_L ? 4'(prev_row[CL]) + 4'(cur_row[CL]) + 4'(below_row[CL]) : 4'd0)
                 + (HAS_R ? 4'(prev_row[CR]) + 4'(cur_row[CR]) + 4'(below_row[CR]) : 4'd0);
        assign new_row[c] = cur_row[c] ? SURVIVE[n] : BIRTH[n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (step) begin
                    if (gens != 8'd0) state_d = PREP;
                    else              done_d  = 1'b1;
                end
            end
            PREP: state_d = RUN;
            RUN: begin
                if (last_row) begin
                    if (gens_left == 8'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PREP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Y; i++) grid[i] <= '0;
            prev_row  <= '0;
            row0_save <= '0;
            r         <= '0;
            gens_left <= '0;
            gen_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
        end else begin
            busy <= (state_d != IDLE);
            done <= done_d;
            case (state_q)
                IDLE: begin
                    if (load_valid && load_ok) grid[load_row] <= load_data;
                    if (step && gens != 8'd0)  gens_left <= gens;
                end
                PREP: begin
                    prev_row  <= WRAP ? grid[Y-1] : '0;
                    row0_save <= grid[0];
                    r         <= '0;
                end
                RUN: begin
                    grid[r]  <= new_row;
                    prev_row <= cur_row;
                    if (last_row) begin
                        r         <= '0;
                        gen_count <= gen_count + 16'd1;
                        gens_left <= gens_left - 8'd1;
                    end else begin
                        r <= r + LOG2Y'(1);
                    end
                end
                default: ;
            endcase
            rd_data <= rd_ok ? grid[rd_row] : '0;
        end
    end

endmodule

// File: tb/tb_life_grid.sv
// Scoreboarded bench for life_grid: default, dead-boundary and B36 instances share stimulus.
module tb_life_grid;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [2:0] load_row = '0;
    logic [7:0] load_data = '0;
    logic       step = 1'b0;
    logic [7:0] gens = '0;
    logic [2:0] rd_row = '0;

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [15:0] gc0, gc1, gc2;
    logic [7:0]  rd0, rd1, rd2;

    always #5 clk = ~clk;

    life_grid u_dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_row(load_row),
        .load_data(load_data), .step(step), .gens(gens), .busy(busy0), .done(done0),
        .gen_count(gc0), .rd_row(rd_row), .rd_data(rd0));

    life_grid #(.WRAP(1'b0)) u_nw (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_row(load_row),
        .load_data(load_data), .step(step), .gens(gens), .busy(busy1), .done(done1),
        .gen_count(gc1), .rd_row(rd_row), .rd_data(rd1));

    life_grid #(.BIRTH(9'b001001000)) u_b36 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_row(load_row),
        .load_data(load_data), .step(step), .gens(gens), .busy(busy2), .done(done2),
        .gen_count(gc2), .rd_row(rd_row), .rd_data(rd2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {int sel; int row; logic [7:0] exp;} rd_exp_t;
    typedef struct {logic [15:0] gc; int busy;} done_exp_t;
    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];

    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    int   busy_cnt = 0;
    int   done_seen = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: pops expected read data and expected completions as the DUT presents them.
    always @(negedge clk) begin
        rd_exp_t   re;
        done_exp_t de;
        logic [7:0] act;
        if (!rst_n) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (rd_vld) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'(rd_q.size()), 1);
                end else begin
                    re = rd_q.pop_front();
                    case (re.sel)
                        1:       act = rd1;
                        2:       act = rd2;
                        default: act = rd0;
                    endcase
                    chk($sformatf("rd_dut%0d_row%0d", re.sel, re.row), act, re.exp);
                end
            end
            if (busy0) busy_cnt++;
            if (done0) begin
                done_seen++;
                chk("done_single_pulse", done_prev, 0);
                chk("busy_low_at_done", busy0, 0);
                if (done_q.size() == 0) begin
                    chk("done_expected", 32'(done_q.size()), 1);
                end else begin
                    de = done_q.pop_front();
                    chk("gen_count_at_done", gc0, de.gc);
                    chk("busy_cycles", busy_cnt, de.busy);
                end
                busy_cnt = 0;
            end
            done_prev = done0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int row, input logic [7:0] data);
        @(negedge clk);
        load_valid = 1'b1;
        load_row   = 3'(row);
        load_data  = data;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic read(input int sel, input int row, input logic [7:0] exp);
        @(negedge clk);
        rd_row = 3'(row);
        rd_req = 1'b1;
        rd_q.push_back('{sel: sel, row: row, exp: exp});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic run(input int g, input int gc_exp, input bit perturb);
        int start;
        start = done_seen;
        @(negedge clk);
        step = 1'b1;
        gens = 8'(g);
        done_q.push_back('{gc: 16'(gc_exp), busy: g * 9});
        @(negedge clk);
        step = 1'b0;
        if (perturb) begin
            repeat (3) @(negedge clk);
            load_valid = 1'b1;
            load_row   = 3'd3;
            load_data  = 8'hFF;
            step       = 1'b1;
            gens       = 8'd5;
            @(negedge clk);
            load_valid = 1'b0;
            step       = 1'b0;
        end
        for (int i = 0; i < g * 9 + 20 && done_seen == start; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_within_budget", done_seen - start, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_gen_count", gc0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_rd_data", rd0, 0);
        for (int r = 0; r < 8; r++) read(0, r, 8'h00);

        // Zero-generation command: immediate done, no busy, grid untouched.
        run(0, 0, 1'b0);
        read(0, 3, 8'h00);

        // Blinker on row 3.
        load(3, 8'h1C);
        run(1, 1, 1'b0);
        for (int r = 0; r < 8; r++) read(0, r, (r >= 2 && r <= 4) ? 8'h08 : 8'h00);
        run(2, 3, 1'b0);
        read(0, 2, 8'h08);
        read(0, 3, 8'h08);
        read(0, 4, 8'h08);
        read(0, 5, 8'h00);

        // Blinker on row 0: toroidal versus dead boundary.
        do_reset();
        load(0, 8'h38);
        run(1, 1, 1'b0);
        read(0, 7, 8'h10);
        read(0, 0, 8'h10);
        read(0, 1, 8'h10);
        read(0, 2, 8'h00);
        read(1, 7, 8'h00);
        read(1, 0, 8'h10);
        read(1, 1, 8'h10);
        run(1, 2, 1'b0);
        for (int r = 0; r < 8; r++) read(1, r, 8'h00);
        read(0, 0, 8'h38);
        read(0, 1, 8'h00);

        // Glider returns home after 32 generations on the 8x8 torus.
        do_reset();
        load(0, 8'h02);
        load(1, 8'h04);
        load(2, 8'h07);
        run(32, 32, 1'b0);
        for (int r = 0; r < 8; r++)
            read(0, r, (r == 0) ? 8'h02 : (r == 1) ? 8'h04 : (r == 2) ? 8'h07 : 8'h00);

        // Six neighbours: only the B36 instance gives birth.
        do_reset();
        load(2, 8'h1C);
        load(3, 8'h00);
        load(4, 8'h1C);
        run(1, 1, 1'b0);
        read(0, 3, 8'h00);
        read(2, 3, 8'h08);

        // Load and step during a run are ignored.
        do_reset();
        load(3, 8'h1C);
        run(1, 1, 1'b1);
        read(0, 2, 8'h08);
        read(0, 3, 8'h08);
        read(0, 4, 8'h08);
        read(0, 1, 8'h00);

        // Reset in the middle of a run.
        @(negedge clk);
        step = 1'b1;
        gens = 8'd3;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_abort", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_rd_data", rd0, 0);
        chk("abort_gen_count", gc0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++) read(0, r, 8'h00);

        repeat (3) @(negedge clk);
        chk("rd_queue_drained", 32'(rd_q.size()), 0);
        chk("done_queue_drained", 32'(done_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_grid.md
# life_grid

Stores an X-by-Y Game of Life grid and advances it by a programmable number of generations on command, one row per clock. It is the sequential successor to the single-cell neighbour-sum logic: it has parametrised grid size, selectable toroidal or dead-boundary edges, and programmable birth/survive rules. The host loads rows, pulses `step`, waits for `done`, and reads rows back through a registered read port.

## Interface
Parameters:
- `X`, 8: grid width in cells (columns), ≥3.
- `Y`, 8: grid height in rows, ≥3.
- `LOG2Y`, 3: width of row indices, ≥ clog2(Y).
- `BIRTH`, 9'b000001000: bit n set means a dead cell with n live neighbours becomes live (B3).
- `SURVIVE`, 9'b000001100: bit n set means a live cell with n live neighbours stays live (S23).
- `WRAP`, 1: 1 = toroidal edges (row and column wrap); 0 = cells outside the grid are dead.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_valid` in 1: write `load_data` into row `load_row`.
- `load_row` in LOG2Y: row index to write.
- `load_data` in X: row contents; bit i is column i.
- `step` in 1: start pulse.
- `gens` in 8: number of generations to run; sampled with `step`.
- `busy` out 1: high while generations are running.
- `done` out 1: one-cycle pulse when a command completes.
- `gen_count` out 16: total generations completed since reset; wraps from 0xFFFF to 0.
- `rd_row` in LOG2Y: row index to read.
- `rd_data` out X: registered value of the grid row `rd_row`, one cycle after it is sampled.

## Operation
- Storage: Y×X register array `grid`.
- FSM states are IDLE, PREP and RUN.
- IDLE:
  - `load_valid` writes `grid[load_row]`. Writes with `load_row` ≥ Y are dropped.
  - `step` with `gens`≠0: latch `gens_left = gens`, go to PREP.
  - `step` with `gens`=0: no grid change; `done` pulses on the next cycle and `busy` stays low.
- PREP (1 cycle):
  - `prev_row ← WRAP ? grid[Y-1] : 0`.
  - `row0_save ← grid[0]`.
  - `r ← 0`.
  - Go to RUN.
- RUN (Y cycles, r = 0..Y-1):
  - Neighbour rows are `above = prev_row` and `cur = grid[r]`.
  - `below = grid[r+1]` for r<Y-1. For r=Y-1, `below = WRAP ? row0_save : 0`.
  - Each cell counts its 8 neighbours in the full 4-bit range 0..8, with no truncation.
  - Horizontal neighbours of column 0 and column X-1 follow `WRAP` the same way as rows.
  - `new = cur ? SURVIVE[n] : BIRTH[n]`.
  - Write `grid[r] ← new row` and `prev_row ← old cur`; then r++.
  - At r=Y-1:
    - `gen_count++`, `gens_left--`.
    - If `gens_left` was 1, go to IDLE and assert `done`.
    - Otherwise go back to PREP.
- Every generation is computed purely from the previous one, with no in-place contamination; `prev_row` and `row0_save` guarantee this.
- `load_valid` and `step` are ignored while `busy`.
- `rd_data` may be sampled at any time. During `busy` it shows the partially updated grid. If `rd_row` ≥ Y, `rd_data` = 0.

## Timing
- Reset values:
  - `grid`, `prev_row`, `row0_save` all 0.
  - State IDLE.
  - `busy`=0, `done`=0, `gen_count`=0, `rd_data`=0.
- Reset asserted mid-run aborts immediately to the reset values; the partially updated grid is cleared.
- `step` is sampled at edge E0. `busy`=1 from E0.
- Each generation takes Y+1 cycles. At edge E0+g·(Y+1), `busy` drops and `done`=1 for exactly one cycle.
- For `gens`=0: `done`=1 after E0 for one cycle; `busy` never rises.
- A load written at edge E is visible on `rd_data` if `rd_row` is sampled at E+1 or later.
- `step` is accepted in the same cycle that `done` is high (state is IDLE).
- If `load_valid` and `step` arrive in the same IDLE cycle, the load is written first and the run uses the new row.

## Test plan
- Reset, then read every row: all 0, `gen_count`=0. Apply `step` with `gens`=0: `done` pulses on the next cycle, `busy` stays 0, grid is unchanged.
- Blinker, default parameters, 8×8:
  - Load row 3 = 0x1C, `step` with `gens`=1.
  - Required: `done` 9 cycles later; rows 2, 3, 4 = 0x08 and all other rows 0.
  - `step` with `gens`=2: row 3 = 0x08 again after 18 cycles; `gen_count`=3.
- Edge modes, blinker on row 0 = 0x38:
  - WRAP=1, 1 generation: rows 7, 0, 1 = 0x10.
  - WRAP=0, 1 generation: rows 0, 1 = 0x10.
  - WRAP=0, a further generation: all rows 0.
- Glider on an 8×8 torus:
  - Load rows 0..2 = 0x02, 0x04, 0x07; `gens`=32.
  - Required: final grid identical to the loaded grid; `busy` high for exactly 288 cycles.
- Rule parameters, 6-neighbour birth:
  - Load rows 2 and 4 = 0x1C, row 3 = 0.
  - Default rules: row 3 bit 3 = 0 after 1 generation.
  - `BIRTH`=9'b001001000 (B36): row 3 bit 3 = 1.
- Robustness:
  - Mid-run `load_valid` and `step` are ignored; the result equals the unperturbed run.
  - `rst_n` low mid-run: `busy` and all rows read 0 immediately.
